fb_scanout: RTL and testbench
=============================

// Module: fb_scanout
// PURPOSE
//  Reads the 4-bit framebuffer that rasterizer_unit writes (fb_x/fb_y/data/fb_we) and scans it out as VGA video.
//  Generates 640x480@60 timing and fetches one pixel per pixel tick.
//  Maps pixels through a color stage and drives RGB, sync and blank outputs.
//  Owns double-buffer selection: a swap handshake with the rasterizer lets it flip buffers only at vblank start.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   h front porch, pixel ticks
//  H_SYNC    96   h sync width, pixel ticks
//  H_BP      48   h back porch, pixel ticks
//  V_ACTIVE  480  visible lines
//  V_FP      10   v front porch, lines
//  V_SYNC    2    v sync width, lines
//  V_BP      33   v back porch, lines
//  CLK_DIV   2    clk cycles per pixel tick (>=2)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-low reset
//  fb_rd_x        out  10  framebuffer read column
//  fb_rd_y        out  9   framebuffer read row
//  fb_rd_buf      out  1   buffer being read (address MSB); = fb_sel
//  fb_rd_data     in   4   read data, valid 1 clk after address (sync RAM)
//  swap_req       in   1   rasterizer requests buffer flip (level)
//  swap_ack       out  1   1-clk pulse: flip performed
//  pal_we         in   1   palette write strobe (used only with FB_PALETTE_EN)
//  pal_idx        in   4   palette entry index
//  pal_rgb        in   12  palette entry {r,g,b}
//  vga_r/g/b      out  4   each: pixel color
//  vga_hs, vga_vs out  1   each: syncs, active-low
//  vga_blank_n    out  1   1 during visible region
//  vblank         out  1   1 while v counter >= V_ACTIVE (undelayed)
// BEHAVIOUR
//  Reset (async, any time): all counters 0, fb_sel 0, vga_r/g/b 0, vga_hs/vs 1, blank_n 0,
//   swap_ack 0, vblank 0, fb_rd_x/y 0. Palette contents survive reset.
//  Pixel tick: tick=1 when div counter == CLK_DIV-1; div counts 0..CLK_DIV-1 and wraps.
//  Counters advance on tick: hc 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800).
//   At hc wrap, vc advances 0..V_TOTAL-1 (525); vc wraps to 0.
//  Stage 0 (tick): fb_rd_x=hc, fb_rd_y=vc when active (hc<H_ACTIVE && vc<V_ACTIVE); else hold last value.
//   Raw: hs_raw=0 for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_raw likewise on vc.
//  Stage 1 (next tick): capture fb_rd_data, active, hs_raw, vs_raw.
//  Stage 2 (next tick): register color and syncs to outputs.
//   RGB forced to 0 when stage-1 active=0.
//  Outputs therefore lag counters by exactly 2 pixel ticks; syncs/blank delayed identically to RGB.
//  Swap FSM states IDLE -> (swap_req=1) PEND -> FLIP -> IDLE:
//   PEND waits for the tick where hc==0 && vc==V_ACTIVE.
//   FLIP toggles fb_sel, pulses swap_ack 1 clk, then returns to IDLE.
//   swap_req dropping while PEND cancels: back to IDLE, no flip.
//   Req rising on the same tick as vblank start flips that frame.
//   Max one flip per frame; req still high after ack gives one more flip next frame (requester must drop req on ack).
//  fb_sel never changes during active video; no tearing.
//  vblank asserted from tick vc becomes V_ACTIVE until vc wraps to 0.
// CONFIGURATION
//  FB_PALETTE_EN defined: 16x12-bit palette regs; pal_we writes pal_rgb to entry pal_idx on that clk.
//   Reset value of entry i is {i,i,i} (gray ramp). Stage 2 outputs palette[pixel].
//   A write to the entry being displayed takes effect on the next tick.
//  FB_PALETTE_EN undefined: no palette storage; pal_* ignored; r=g=b=pixel (4-bit gray).
// TESTING
//  Release reset, CLK_DIV=2 -> first vga_hs low exactly (640+16)+2 ticks = 1316 clk after first tick;
//   low for 96 ticks; line period 1600 clk.
//  Memory model returns fb_rd_data = fb_rd_x[3:0] -> vga_r sequence 0,1,..,15,0.. on line 0;
//   first blank_n=1 at tick 2; RGB 0 in porches.
//  swap_req=1 at vc=100 -> swap_ack single pulse at the tick hc=0, vc=480; fb_rd_buf toggles 0->1; req held -> second ack next frame.
//  swap_req pulsed high at vc=200, low at vc=300 -> no ack, fb_sel unchanged.
//  Assert reset low at hc=300, vc=250 -> outputs immediately at reset values; after release, counters restart at 0,0.
//  FB_PALETTE_EN: write idx 5 = 12'hF00, pixels all 5 -> r=F, g=0, b=0; without macro -> r=g=b=5.

Source files
------------

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - VGA scanout of a double-buffered 4-bit framebuffer with buffer-swap handshake
// Optional FB_PALETTE_EN: map pixels through a 16-entry 12-bit palette instead of 4-bit gray.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  fb_rd_x,
  output logic [8:0]  fb_rd_y,
  output logic        fb_rd_buf,
  input  logic [3:0]  fb_rd_data,
  input  logic        swap_req,
  output logic        swap_ack,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_FLIP} swap_state_t;

  logic [DW-1:0] div;
  logic [9:0]    hc, vc;
  logic          tick, active, hs_raw, vs_raw, vb_start;
  logic          s0_act, s0_hs, s0_vs;
  logic          s1_act, s1_hs, s1_vs;
  logic [3:0]    s1_pix;
  logic [11:0]   color;
  logic          fb_sel;
  swap_state_t   state, state_nxt;

  assign tick     = (div == DIV_LAST);
  assign active   = (hc < H_ACT) && (vc < V_ACT);
  assign hs_raw   = !((hc >= HS_BEG) && (hc < HS_END));
  assign vs_raw   = !((vc >= VS_BEG) && (vc < VS_END));
  assign vb_start = tick && (hc == 10'd0) && (vc == V_ACT);
  assign vblank   = (vc >= V_ACT);
  assign fb_rd_buf = fb_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      hc  <= '0;
      vc  <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? 10'd0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

  // Three-stage pixel pipeline: address, RAM data capture, output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_rd_x     <= '0;
      fb_rd_y     <= '0;
      s0_act      <= 1'b0;
      s0_hs       <= 1'b1;
      s0_vs       <= 1'b1;
      s1_act      <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_pix      <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (tick) begin
      if (active) begin
        fb_rd_x <= hc;
        fb_rd_y <= vc[8:0];
      end
      s0_act      <= active;
      s0_hs       <= hs_raw;
      s0_vs       <= vs_raw;
      s1_act      <= s0_act;
      s1_hs       <= s0_hs;
      s1_vs       <= s0_vs;
      s1_pix      <= fb_rd_data;
      vga_r       <= s1_act ? color[11:8] : 4'd0;
      vga_g       <= s1_act ? color[7:4]  : 4'd0;
      vga_b       <= s1_act ? color[3:0]  : 4'd0;
      vga_hs      <= s1_hs;
      vga_vs      <= s1_vs;
      vga_blank_n <= s1_act;
    end
  end

`ifdef FB_PALETTE_EN
  // Entries are stored XORed with the gray ramp so zeroed flops read back as {i,i,i};
  // no reset term, so written colors survive reset.
  logic [11:0] pal_q [16];

  always_ff @(posedge clk) begin
    if (pal_we) pal_q[pal_idx] <= pal_rgb ^ {pal_idx, pal_idx, pal_idx};
  end

  assign color = pal_q[s1_pix] ^ {s1_pix, s1_pix, s1_pix};
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_idx, pal_rgb};
  assign color      = {s1_pix, s1_pix, s1_pix};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      fb_sel <= 1'b0;
    end else begin
      state  <= state_nxt;
      fb_sel <= fb_sel ^ (state == S_FLIP);
    end
  end

  // A request arriving on the vblank-start tick itself flips straight away.
  always_comb begin
    state_nxt = state;
    swap_ack  = 1'b0;
    case (state)
      S_IDLE: if (swap_req) state_nxt = vb_start ? S_FLIP : S_PEND;
      S_PEND: begin
        if (!swap_req)     state_nxt = S_IDLE;
        else if (vb_start) state_nxt = S_FLIP;
      end
      S_FLIP: begin
        swap_ack  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - self-checking bench for fb_scanout (small timing instance plus default-timing instance)
// Expected palette results follow FB_PALETTE_EN when it is defined.
module tb_fb_scanout;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  fb_rd_x;
  logic [8:0]  fb_rd_y;
  logic        fb_rd_buf;
  logic [3:0]  fb_rd_data;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = 4'd0;
  logic [11:0] pal_rgb = 12'd0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vblank;
  logic        mem_mode = 1'b0;

  logic [9:0]  d_rd_x;
  logic [8:0]  d_rd_y;
  logic        d_rd_buf, d_ack, d_hs, d_vs, d_bn, d_vb;
  logic [3:0]  d_r, d_g, d_b;

  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) fb_rd_data <= mem_mode ? 4'd5 : fb_rd_x[3:0];

  fb_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .fb_rd_x(fb_rd_x), .fb_rd_y(fb_rd_y), .fb_rd_buf(fb_rd_buf),
    .fb_rd_data(fb_rd_data), .swap_req(swap_req), .swap_ack(swap_ack), .pal_we(pal_we),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vblank(vblank));

  fb_scanout u_def (
    .clk(clk), .reset(reset), .fb_rd_x(d_rd_x), .fb_rd_y(d_rd_y), .fb_rd_buf(d_rd_buf),
    .fb_rd_data(4'd0), .swap_req(1'b0), .swap_ack(d_ack), .pal_we(1'b0),
    .pal_idx(4'd0), .pal_rgb(12'd0), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_bn), .vblank(d_vb));

  typedef struct {
    int         k;
    logic       hs, vs, bn, vb;
    logic [3:0] r;
    logic [9:0] rx;
    logic [8:0] ry;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, swap_ack, vblank,
                 fb_rd_x, fb_rd_y, fb_rd_buf},
          {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0});
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(name);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int f1, f2, n_ack, a1, a2;
    logic [3:0] er, eg, eb;

    //          k    hs vs bn vb  r   rx  ry
    vt[0]  = '{1,   1, 1, 0, 0, 0,  1,  0};
    vt[1]  = '{2,   1, 1, 1, 0, 0,  2,  0};
    vt[2]  = '{3,   1, 1, 1, 0, 1,  3,  0};
    vt[3]  = '{17,  1, 1, 1, 0, 15, 15, 0};
    vt[4]  = '{18,  1, 1, 0, 0, 0,  15, 0};
    vt[5]  = '{22,  0, 1, 0, 0, 0,  15, 0};
    vt[6]  = '{27,  0, 1, 0, 0, 0,  15, 0};
    vt[7]  = '{28,  1, 1, 0, 0, 0,  15, 0};
    vt[8]  = '{33,  1, 1, 1, 0, 1,  3,  1};
    vt[9]  = '{238, 1, 1, 0, 0, 0,  15, 7};
    vt[10] = '{239, 1, 1, 0, 1, 0,  15, 7};
    vt[11] = '{302, 1, 0, 0, 1, 0,  15, 7};
    vt[12] = '{361, 1, 0, 0, 1, 0,  15, 7};
    vt[13] = '{362, 1, 1, 0, 1, 0,  15, 7};
    vt[14] = '{448, 1, 1, 0, 1, 0,  15, 7};
    vt[15] = '{449, 1, 1, 0, 0, 0,  15, 7};
    vt[16] = '{450, 1, 1, 0, 0, 0,  0,  0};
    vt[17] = '{455, 1, 1, 1, 0, 3,  5,  0};

    // Default 640x480 timing: first tick lands on cycle 2.
    do_reset("reset_vals_0");
    while (d_hs && cyc < 3000) step();
    f1 = cyc;
    check("def_hs_first_fall", f1, 1318);
    while (!d_hs && cyc < 3000) step();
    check("def_hs_low_width", cyc - f1, 192);
    while (d_hs && cyc < 4000) step();
    f2 = cyc;
    check("def_line_period", f2 - f1, 1600);

    // Small timing table: tick k lands on cycle 2+2k.
    do_reset("reset_vals_1");
    for (int i = 0; i < 18; i++) begin
      step_to(2 + 2 * vt[i].k);
      check($sformatf("vec%0d_k%0d", i, vt[i].k),
            {vga_hs, vga_vs, vga_blank_n, vblank, vga_r, vga_g, vga_b, fb_rd_x, fb_rd_y},
            {vt[i].hs, vt[i].vs, vt[i].bn, vt[i].vb, vt[i].r, vt[i].r, vt[i].r, vt[i].rx, vt[i].ry});
    end

    // Held request: flips at each vblank start (cycles 482, 1382).
    do_reset("reset_vals_2");
    step_to(200);
    swap_req = 1'b1;
    n_ack = 0; a1 = -1; a2 = -1;
    while (cyc < 2300) begin
      step();
      if (swap_ack) begin
        n_ack++;
        if (a1 < 0) a1 = cyc;
        else if (a2 < 0) begin
          a2 = cyc;
          swap_req = 1'b0;
        end
      end
      if (cyc == 481)  check("buf_before_flip", fb_rd_buf, 1'b0);
      if (cyc == 483)  check("buf_after_flip1", fb_rd_buf, 1'b1);
      if (cyc == 1383) check("buf_after_flip2", fb_rd_buf, 1'b0);
    end
    check("ack1_cycle", a1, 482);
    check("ack2_cycle", a2, 1382);
    check("ack_count", n_ack, 2);

    // Request raised then dropped before vblank: no flip at cycle 3182.
    step_to(2822);
    swap_req = 1'b1;
    step_to(3002);
    swap_req = 1'b0;
    n_ack = 0;
    while (cyc < 3300) begin
      step();
      if (swap_ack) n_ack++;
    end
    check("cancel_no_ack", n_ack, 0);
    check("cancel_buf", fb_rd_buf, 1'b0);

    // Request rising on the vblank-start tick flips that frame.
    step_to(4081);
    swap_req = 1'b1;
    step();
    check("same_tick_ack", swap_ack, 1'b1);
    swap_req = 1'b0;
    step();
    check("same_tick_ack_pulse", {swap_ack, fb_rd_buf}, 2'b01);

    // Mid-frame asynchronous reset at vc=5, hc=10.
    step_to(4822);
    check("pre_reset_pixel", {vga_blank_n, vga_r}, {1'b1, 4'd8});
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset_vals");
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    step_to(4);
    check("restart_tick1", {vga_blank_n, fb_rd_x, fb_rd_y}, {1'b0, 10'd1, 9'd0});
    step_to(6);
    check("restart_tick2", {vga_blank_n, vga_r, fb_rd_x, fb_rd_y}, {1'b1, 4'd0, 10'd2, 9'd0});

    // Color stage with every pixel = 5.
    step_to(20);
    mem_mode = 1'b1;
    pal_we = 1'b1;
    pal_idx = 4'd5;
    pal_rgb = 12'hF00;
    step();
    pal_we = 1'b0;
`ifdef FB_PALETTE_EN
    er = 4'hF; eg = 4'h0; eb = 4'h0;
`else
    er = 4'h5; eg = 4'h5; eb = 4'h5;
`endif
    step_to(68);
    check("color_stage", {vga_r, vga_g, vga_b}, {er, eg, eb});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
